mem_region_ctrl: RTL and testbench
==================================

Name: mem_region_ctrl

Overview:
- Parametrised memory controller between the CPU/DMA bus, the graphics read port and NUM_REGIONS dual-port block RAMs (BIOS, EWRAM, IWRAM, palette, VRAM, OAM).
- Decodes addresses against a package region table and issues one BRAM access per bus request.
- Inserts per-region wait states, generates byte write enables with write-data lane replication, and flags unmapped or read-only accesses.
- Graphics port is a fixed-latency, read-only pipeline, independent of the bus FSM.

Parameters:
- NUM_REGIONS, 6, number of entries used from the package region table.
- BRAM_LAT, 1, BRAM read latency in cycles (1..3).
- WAIT_W, 3, width of the wait-state counter; max wait = 2^WAIT_W-1.

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- bus_req  in  1  bus access request; held until completion
- bus_addr  in  32  byte address
- bus_wdata  in  32  write data, value in low lanes
- bus_size  in  2  MEM_SIZE_BYTE/HALF/WORD; 2'b11 reserved
- bus_write  in  1  1=write, 0=read
- bus_rdata  out  32  read word, valid in completion cycle
- bus_pause  out  1  stall the requester
- bus_fault  out  1  one-cycle pulse at completion of a faulting access
- gfx_req  in  1  graphics read request
- gfx_addr  in  32  graphics byte address
- gfx_rdata  out  32  graphics read word
- gfx_valid  out  1  gfx_rdata valid
- mem_en_a  out  NUM_REGIONS  port-A enable, one-hot per region
- mem_we_a  out  4  port-A byte write enables
- mem_addr_a  out  32  region-relative offset
- mem_wdata_a  out  32  lane-replicated write data
- mem_rdata_a  in  32*NUM_REGIONS  port-A read data, region i at [32i+31:32i]
- mem_en_b  out  NUM_REGIONS  port-B enable
- mem_addr_b  out  32  port-B offset
- mem_rdata_b  in  32*NUM_REGIONS  port-B read data

Behaviour:
- Interface: reset is asynchronous, active-high; all state updates on the rising edge of clock.
- While reset=1: mem_en_a and mem_en_b are all ones, so BRAM output registers clear. All other outputs are 0, FSM=IDLE, counters and pipelines cleared.
- Decode: region i hits when REGION_BASE[i] <= addr < REGION_BASE[i]+REGION_SIZE[i]. Offset = addr - REGION_BASE[i]. On overlap, the lowest index wins. No hit means unmapped.
- Bus FSM:
  - IDLE: bus_pause = bus_req. When bus_req=1, latch addr, size, write, wdata and region, then go to ISSUE. If the access is unmapped or size=2'b11, go to DONE with the fault flag set instead.
  - ISSUE (1 cycle): mem_en_a[r]=1, mem_addr_a=offset, mem_wdata_a and mem_we_a driven; bus_pause=1. Load cnt = REGION_WAIT[r] + BRAM_LAT - 1. If cnt==0 go to DONE, else go to WAIT.
  - WAIT: bus_pause=1, mem_en_a=0, cnt decrements; go to DONE when cnt reaches 1.
  - DONE (1 cycle): bus_pause=0. bus_rdata = mem_rdata_a slice r for reads, 0 for writes or faults. bus_fault pulses if flagged. Next state is IDLE.
  - The requester's bus_req seen during DONE belongs to the finished access. A new request is sampled in IDLE on the next cycle.
- Latency from request to completion = 2 + REGION_WAIT[r] + BRAM_LAT - 1 cycles. Example: 2 cycles for W=0, BRAM_LAT=1.
- Read-only region (REGION_WRITABLE[r]=0) on a write: ISSUE still runs with mem_we_a=4'b0000; fault pulses at DONE.
- Byte enables:
  - BYTE: one-hot on addr[1:0].
  - HALF: addr[1] ? 1100 : 0011.
  - WORD: 1111.
  - Enables are nonzero only in ISSUE of a write.
- Write data lanes: BYTE replicates wdata[7:0] x4; HALF replicates wdata[15:0] x2; WORD passes through.
- Read data is returned as a full aligned word; the CPU extracts and aligns.
- Graphics pipeline:
  - Same-cycle decode of gfx_addr. mem_en_b[r] = gfx_req & hit; mem_addr_b = offset.
  - Region index and hit flag pass through a BRAM_LAT-deep shift register.
  - gfx_valid = delayed gfx_req; gfx_rdata = selected slice, or 0 if unmapped.
  - Accepts one request per cycle. Never stalls and never interacts with the bus FSM.
- Reset asserted mid-access: the access is abandoned, no write enable is issued after reset, and the FSM is in IDLE on release.

Decomposition:
- Package gba_mem_pkg:
  - MEM_SIZE_* constants.
  - REGION_BASE/SIZE/WAIT/WRITABLE arrays: BIOS 0x0000_0000/0x4000/0/RO; EWRAM 0x0200_0000/0x40000/2/RW; IWRAM 0x0300_0000/0x8000/0/RW; palette 0x0500_0000/0x400/0/RW; VRAM 0x0600_0000/0x18000/0/RW; OAM 0x0700_0000/0x400/0/RW.
  - Bus FSM state enum.
- Sub-module mem_byte_lane: combinational byte enables plus write-data replication from addr[1:0], size and write.

Test Plan:
- Word read IWRAM 0x0300_0010, BRAM returns 0xDEADBEEF -> pause high 1 cycle, DONE at cycle 2 with rdata=0xDEADBEEF, fault=0.
- Byte write 0xA5 to EWRAM 0x0200_0003 -> in ISSUE: mem_we_a=1000, wdata=0xA5A5A5A5, mem_addr_a=0x3; completion at cycle 4 (W=2).
- Half write to 0x0000_0002 (BIOS) -> mem_we_a=0000, bus_fault pulses at DONE.
- Read 0x0400_0000 (unmapped) -> no mem_en_a, completion next cycle, rdata=0, fault=1.
- Gfx reads to VRAM 0x0600_0000 and OAM 0x0700_0004 on consecutive cycles during a bus EWRAM read -> gfx_valid on cycles +1 and +2 with the correct slices; bus timing unchanged.
- Reset asserted during WAIT of an EWRAM write -> outputs 0, mem_en all ones; after release, IDLE and no write issued.

Source files
------------

// File: rtl/mem_region_ctrl_pkg.sv
// Shared constants for the GBA memory controller: access sizes,
// the region map (base, size, wait states, writability) and the bus FSM states.
package gba_mem_pkg;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
   localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
   localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

   localparam int MAX_REGIONS = 6;

   // Region order: BIOS, EWRAM, IWRAM, palette, VRAM, OAM
   localparam logic [31:0] REGION_BASE [MAX_REGIONS] = '{
      32'h0000_0000, 32'h0200_0000, 32'h0300_0000,
      32'h0500_0000, 32'h0600_0000, 32'h0700_0000
   };

   localparam logic [31:0] REGION_SIZE [MAX_REGIONS] = '{
      32'h0000_4000, 32'h0004_0000, 32'h0000_8000,
      32'h0000_0400, 32'h0001_8000, 32'h0000_0400
   };

   localparam int REGION_WAIT [MAX_REGIONS] = '{0, 2, 0, 0, 0, 0};

   localparam bit REGION_WRITABLE [MAX_REGIONS] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

   typedef enum logic [1:0] {
      BUS_IDLE,
      BUS_ISSUE,
      BUS_WAIT,
      BUS_DONE
   } bus_state_e;

endpackage

// File: rtl/mem_region_ctrl_byte_lane.sv
// Byte-enable generation and write-data lane replication for one bus access.
module mem_byte_lane
   import gba_mem_pkg::*;
(
   input  logic [1:0]  addr_i,
   input  logic [1:0]  size_i,
   input  logic        write_i,
   input  logic [31:0] wdata_i,
   output logic [3:0]  we_o,
   output logic [31:0] wdata_o
);

   // Pick the lanes touched by the access and copy the low data bytes into every lane
   always_comb begin
      we_o    = 4'b0000;
      wdata_o = wdata_i;
      case (size_i)
         MEM_SIZE_BYTE: begin
            we_o    = 4'b0001 << addr_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         MEM_SIZE_HALF: begin
            we_o    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
         end
         MEM_SIZE_WORD: begin
            we_o    = 4'b1111;
         end
         default: begin
            we_o    = 4'b0000;
         end
      endcase
      if (!write_i) begin
         we_o = 4'b0000;
      end
   end

endmodule

// File: rtl/mem_region_ctrl.sv
// Memory region controller: decodes bus and graphics addresses onto the
// per-region dual-port BRAMs, inserting wait states on the bus side and
// running a fixed-latency read pipeline on the graphics side.
module mem_region_ctrl
   import gba_mem_pkg::*;
#(
   parameter int NUM_REGIONS = 6,
   parameter int BRAM_LAT    = 1,
   parameter int WAIT_W      = 3
)(
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      bus_req,
   input  logic [31:0]               bus_addr,
   input  logic [31:0]               bus_wdata,
   input  logic [1:0]                bus_size,
   input  logic                      bus_write,
   output logic [31:0]               bus_rdata,
   output logic                      bus_pause,
   output logic                      bus_fault,
   input  logic                      gfx_req,
   input  logic [31:0]               gfx_addr,
   output logic [31:0]               gfx_rdata,
   output logic                      gfx_valid,
   output logic [NUM_REGIONS-1:0]    mem_en_a,
   output logic [3:0]                mem_we_a,
   output logic [31:0]               mem_addr_a,
   output logic [31:0]               mem_wdata_a,
   input  logic [32*NUM_REGIONS-1:0] mem_rdata_a,
   output logic [NUM_REGIONS-1:0]    mem_en_b,
   output logic [31:0]               mem_addr_b,
   input  logic [32*NUM_REGIONS-1:0] mem_rdata_b
);

   localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
   localparam int CNT_W = WAIT_W + 2;

   typedef struct packed {
      logic             hit;
      logic [IDX_W-1:0] idx;
      logic [31:0]      offset;
   } decode_t;

   // Lowest matching region wins; the end bound is compared at 33 bits so it cannot wrap
   function automatic decode_t decodeAddr(input logic [31:0] addr);
      decode_t d;
      d = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if ((addr >= REGION_BASE[i]) &&
             ({1'b0, addr} < ({1'b0, REGION_BASE[i]} + {1'b0, REGION_SIZE[i]}))) begin
            d.hit    = 1'b1;
            d.idx    = IDX_W'(i);
            d.offset = addr - REGION_BASE[i];
         end
      end
      return d;
   endfunction

   bus_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      offset_q, offset_d;
   logic [1:0]       addrLow_q, addrLow_d;
   logic [1:0]       size_q, size_d;
   logic             write_q, write_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [IDX_W-1:0] region_q, region_d;
   logic             fault_q, fault_d;

   logic [BRAM_LAT-1:0] gfxValid_q;
   logic [BRAM_LAT-1:0] gfxHit_q;
   logic [IDX_W-1:0]    gfxIdx_q [BRAM_LAT];

   decode_t          busDec;
   decode_t          gfxDec;
   logic             regionWritable;
   logic             badAccess;
   logic [CNT_W-1:0] cntLoad;
   logic [3:0]       laneWe;
   logic [31:0]      laneWdata;

   assign busDec         = decodeAddr(bus_addr);
   assign gfxDec         = decodeAddr(gfx_addr);
   assign regionWritable = REGION_WRITABLE[region_q];
   assign badAccess      = !busDec.hit || (bus_size == 2'b11);
   assign cntLoad        = CNT_W'(REGION_WAIT[region_q] + BRAM_LAT - 1);

   mem_byte_lane u_lane (
      .addr_i  (addrLow_q),
      .size_i  (size_q),
      .write_i (write_q & regionWritable),
      .wdata_i (wdata_q),
      .we_o    (laneWe),
      .wdata_o (laneWdata)
   );

   // Bus FSM state, wait counter and the latched request
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= BUS_IDLE;
         cnt_q     <= '0;
         offset_q  <= '0;
         addrLow_q <= '0;
         size_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         region_q  <= '0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         offset_q  <= offset_d;
         addrLow_q <= addrLow_d;
         size_q    <= size_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         region_q  <= region_d;
         fault_q   <= fault_d;
      end
   end

   // Next-state logic: bad accesses skip straight to DONE, the rest wait out region latency
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      offset_d  = offset_q;
      addrLow_d = addrLow_q;
      size_d    = size_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      region_d  = region_q;
      fault_d   = fault_q;
      unique case (state_q)
         BUS_IDLE: begin
            if (bus_req) begin
               offset_d  = busDec.offset;
               addrLow_d = bus_addr[1:0];
               size_d    = bus_size;
               write_d   = bus_write;
               wdata_d   = bus_wdata;
               region_d  = busDec.idx;
               fault_d   = badAccess || (bus_write && !REGION_WRITABLE[busDec.idx]);
               state_d   = badAccess ? BUS_DONE : BUS_ISSUE;
            end
         end
         BUS_ISSUE: begin
            cnt_d   = cntLoad;
            state_d = (cntLoad == '0) ? BUS_DONE : BUS_WAIT;
         end
         BUS_WAIT: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = BUS_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         BUS_DONE: begin
            state_d = BUS_IDLE;
         end
         default: begin
            state_d = BUS_IDLE;
         end
      endcase
   end

   // Graphics pipeline: region and hit flag travel alongside the BRAM read latency
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gfxValid_q <= '0;
         gfxHit_q   <= '0;
         for (int s = 0; s < BRAM_LAT; s++) begin
            gfxIdx_q[s] <= '0;
         end
      end else begin
         gfxValid_q[0] <= gfx_req;
         gfxHit_q[0]   <= gfx_req & gfxDec.hit;
         gfxIdx_q[0]   <= gfxDec.idx;
         for (int s = 1; s < BRAM_LAT; s++) begin
            gfxValid_q[s] <= gfxValid_q[s-1];
            gfxHit_q[s]   <= gfxHit_q[s-1];
            gfxIdx_q[s]   <= gfxIdx_q[s-1];
         end
      end
   end

   // Output drive; during reset every BRAM port is enabled so its output register clears
   always_comb begin
      bus_rdata   = '0;
      bus_pause   = 1'b0;
      bus_fault   = 1'b0;
      mem_en_a    = '0;
      mem_we_a    = '0;
      mem_addr_a  = '0;
      mem_wdata_a = '0;
      mem_en_b    = '0;
      mem_addr_b  = '0;
      gfx_valid   = 1'b0;
      gfx_rdata   = '0;
      if (reset) begin
         mem_en_a = '1;
         mem_en_b = '1;
      end else begin
         unique case (state_q)
            BUS_IDLE: begin
               bus_pause = bus_req;
            end
            BUS_ISSUE: begin
               bus_pause   = 1'b1;
               mem_en_a    = NUM_REGIONS'(1) << region_q;
               mem_addr_a  = offset_q;
               mem_wdata_a = laneWdata;
               mem_we_a    = laneWe;
            end
            BUS_WAIT: begin
               bus_pause = 1'b1;
            end
            BUS_DONE: begin
               bus_fault = fault_q;
               if (!write_q && !fault_q) begin
                  bus_rdata = mem_rdata_a[32*region_q +: 32];
               end
            end
            default: begin
               bus_pause = 1'b0;
            end
         endcase
         if (gfx_req && gfxDec.hit) begin
            mem_en_b   = NUM_REGIONS'(1) << gfxDec.idx;
            mem_addr_b = gfxDec.offset;
         end
         gfx_valid = gfxValid_q[BRAM_LAT-1];
         if (gfxHit_q[BRAM_LAT-1]) begin
            gfx_rdata = mem_rdata_b[32*gfxIdx_q[BRAM_LAT-1] +: 32];
         end
      end
   end

endmodule

// File: tb/tb_mem_region_ctrl.sv
// Randomised bench for mem_region_ctrl with BRAM models on both ports and a
// reference model built directly from the region map.
module tb_mem_region_ctrl;

   localparam int NR = 6;

   localparam logic [31:0] TB_BASE [NR] = '{32'h0000_0000, 32'h0200_0000, 32'h0300_0000,
                                            32'h0500_0000, 32'h0600_0000, 32'h0700_0000};
   localparam logic [31:0] TB_SIZE [NR] = '{32'h4000, 32'h40000, 32'h8000, 32'h400, 32'h18000, 32'h400};
   localparam int TB_WAIT [NR] = '{0, 2, 0, 0, 0, 0};
   localparam bit TB_WR   [NR] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             bus_req = 1'b0;
   logic [31:0]      bus_addr = '0;
   logic [31:0]      bus_wdata = '0;
   logic [1:0]       bus_size = '0;
   logic             bus_write = 1'b0;
   logic [31:0]      bus_rdata;
   logic             bus_pause;
   logic             bus_fault;
   logic             gfx_req = 1'b0;
   logic [31:0]      gfx_addr = '0;
   logic [31:0]      gfx_rdata;
   logic             gfx_valid;
   logic [NR-1:0]    mem_en_a;
   logic [3:0]       mem_we_a;
   logic [31:0]      mem_addr_a;
   logic [31:0]      mem_wdata_a;
   logic [32*NR-1:0] mem_rdata_a;
   logic [NR-1:0]    mem_en_b;
   logic [31:0]      mem_addr_b;
   logic [32*NR-1:0] mem_rdata_b;

   logic [31:0] rdA [NR];
   logic [31:0] rdB [NR];

   int checkCount = 0;
   int errorCount = 0;
   bit gfxOn = 1'b0;

   mem_region_ctrl #(.NUM_REGIONS(NR), .BRAM_LAT(1), .WAIT_W(3)) dut (
      .clock(clock), .reset(reset),
      .bus_req(bus_req), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_size(bus_size), .bus_write(bus_write),
      .bus_rdata(bus_rdata), .bus_pause(bus_pause), .bus_fault(bus_fault),
      .gfx_req(gfx_req), .gfx_addr(gfx_addr), .gfx_rdata(gfx_rdata), .gfx_valid(gfx_valid),
      .mem_en_a(mem_en_a), .mem_we_a(mem_we_a), .mem_addr_a(mem_addr_a),
      .mem_wdata_a(mem_wdata_a), .mem_rdata_a(mem_rdata_a),
      .mem_en_b(mem_en_b), .mem_addr_b(mem_addr_b), .mem_rdata_b(mem_rdata_b)
   );

   always #5 clock = ~clock;

   // Content of each BRAM is a fixed function of region and offset
   function automatic logic [31:0] bramWordA(input int r, input logic [31:0] off);
      return (off * 32'h9E37_79B1) ^ (32'(r) << 24) ^ 32'h1234_5678;
   endfunction

   function automatic logic [31:0] bramWordB(input int r, input logic [31:0] off);
      return (off * 32'h85EB_CA6B) ^ (32'(r) << 20) ^ 32'hCAFE_0000;
   endfunction

   // One-cycle-latency BRAM models: output register loads when the port is enabled
   always @(posedge clock) begin
      for (int i = 0; i < NR; i++) begin
         if (mem_en_a[i]) rdA[i] <= bramWordA(i, mem_addr_a);
         if (mem_en_b[i]) rdB[i] <= bramWordB(i, mem_addr_b);
      end
   end

   always_comb begin
      mem_rdata_a = '0;
      mem_rdata_b = '0;
      for (int i = 0; i < NR; i++) begin
         mem_rdata_a[32*i +: 32] = rdA[i];
         mem_rdata_b[32*i +: 32] = rdB[i];
      end
   end

   // Region lookup from the map; -1 means unmapped
   function automatic int findRegion(input logic [31:0] addr);
      for (int r = 0; r < NR; r++) begin
         if (addr >= TB_BASE[r] && (addr - TB_BASE[r]) < TB_SIZE[r]) return r;
      end
      return -1;
   endfunction

   function automatic logic [31:0] randAddr();
      int r;
      int sel;
      r   = $urandom_range(0, NR - 1);
      sel = $urandom_range(0, 9);
      if (sel < 7) return TB_BASE[r] + ($urandom() % TB_SIZE[r]);
      if (sel == 7) return TB_BASE[r] + TB_SIZE[r];
      if (sel == 8) return TB_BASE[r] + TB_SIZE[r] - 32'd1;
      return $urandom();
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One bus transaction, called and returning one time unit after a rising edge
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic write);
      int r;
      bit expIssue, expWr, expFault;
      int expLat, lanes, first, doneCyc, enCount, strayWe;
      logic [31:0] expOff, expData, expRdata, seenEn, seenAddr, seenWdata, gotRdata, gotFault;
      logic [3:0] expWe, seenWe;

      r        = findRegion(addr);
      expIssue = (r >= 0) && (size != 2'b11);
      expWr    = expIssue && write && TB_WR[r];
      expFault = !expIssue || (write && !TB_WR[r]);
      expLat   = expIssue ? 2 + TB_WAIT[r] : 1;
      expOff   = (r >= 0) ? addr - TB_BASE[r] : 32'd0;
      lanes    = 1 << size;
      first    = (size == 2'b00) ? int'(addr[1:0]) : (size == 2'b01) ? int'(addr[1:0] & 2'b10) : 0;
      expWe    = expWr ? 4'(((1 << lanes) - 1) << first) : 4'b0000;
      expData  = '0;
      for (int k = 0; k < 4; k++) expData[8*k +: 8] = wdata[8*(k % lanes) +: 8];
      expRdata = (!expFault && !write) ? bramWordA(r, expOff) : 32'd0;

      bus_addr  = addr;
      bus_wdata = wdata;
      bus_size  = size;
      bus_write = write;
      bus_req   = 1'b1;
      #1;
      checkOutput("pauseIdle", 32'(bus_pause), 32'd1);

      doneCyc = 0; enCount = 0; strayWe = 0;
      seenEn = '0; seenAddr = '0; seenWdata = '0; seenWe = '0; gotRdata = '0; gotFault = '0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(posedge clock); #1;
         if (mem_en_a != '0) begin
            enCount++;
            seenEn = 32'(mem_en_a); seenAddr = mem_addr_a; seenWe = mem_we_a; seenWdata = mem_wdata_a;
         end else if (mem_we_a != 4'b0000) begin
            strayWe++;
         end
         if (!bus_pause) begin
            doneCyc  = cyc;
            gotRdata = bus_rdata;
            gotFault = 32'(bus_fault);
            break;
         end
      end
      bus_req = 1'b0;

      checkOutput("latency", 32'(doneCyc), 32'(expLat));
      checkOutput("issueCount", 32'(enCount), expIssue ? 32'd1 : 32'd0);
      checkOutput("strayWe", 32'(strayWe), 32'd0);
      checkOutput("rdata", gotRdata, expRdata);
      checkOutput("fault", gotFault, 32'(expFault));
      if (expIssue) begin
         checkOutput("enA", seenEn, 32'd1 << r);
         checkOutput("addrA", seenAddr, expOff);
         checkOutput("weA", 32'(seenWe), 32'(expWe));
         if (expWr) checkOutput("wdataA", seenWdata, expData);
      end
      @(posedge clock); #1;
      checkOutput("faultPulse", 32'(bus_fault), 32'd0);
      checkOutput("pauseAfter", 32'(bus_pause), 32'd0);
   endtask

   // Graphics traffic and its one-cycle-later check, running beside the bus
   initial begin
      logic        expValid;
      logic [31:0] expData, expEn, expAddr;
      int          r;
      expValid = 1'b0;
      expData  = '0;
      forever begin
         @(posedge clock); #1;
         if (gfxOn) begin
            checkOutput("gfxValid", 32'(gfx_valid), 32'(expValid));
            checkOutput("gfxData", gfx_rdata, expData);
         end
         if (gfxOn && $urandom_range(0, 3) != 0) begin
            gfx_req  = 1'b1;
            gfx_addr = ($urandom_range(0, 1) == 0) ? 32'h0600_0000 + ($urandom() % 32'h18000)
                                                   : randAddr();
         end else begin
            gfx_req  = 1'b0;
            gfx_addr = $urandom();
         end
         r        = findRegion(gfx_addr);
         expValid = gfx_req;
         expData  = (gfx_req && r >= 0) ? bramWordB(r, gfx_addr - TB_BASE[r]) : 32'd0;
         expEn    = (gfx_req && r >= 0) ? (32'd1 << r) : 32'd0;
         expAddr  = (gfx_req && r >= 0) ? gfx_addr - TB_BASE[r] : 32'd0;
         #1;
         if (gfxOn) begin
            checkOutput("gfxEnB", 32'(mem_en_b), expEn);
            checkOutput("gfxAddrB", mem_addr_b, expAddr);
         end
      end
   end

   // Abort guard so a stuck run still ends
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset state, directed cases, random traffic, reset mid-access
   initial begin
      int weSeen, enSeen;
      #2 reset = 1'b1;
      @(posedge clock); #1;
      checkOutput("rstEnA", 32'(mem_en_a), 32'h3F);
      checkOutput("rstEnB", 32'(mem_en_b), 32'h3F);
      checkOutput("rstPause", 32'(bus_pause), 32'd0);
      checkOutput("rstWe", 32'(mem_we_a), 32'd0);
      checkOutput("rstGfxValid", 32'(gfx_valid), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      checkOutput("idleEnA", 32'(mem_en_a), 32'd0);
      @(posedge clock); #1;

      applyStimulus(32'h0300_0010, 32'h0, 2'b10, 1'b0);
      applyStimulus(32'h0200_0003, 32'h0000_00A5, 2'b00, 1'b1);
      applyStimulus(32'h0000_0002, 32'h0000_1234, 2'b01, 1'b1);
      applyStimulus(32'h0400_0000, 32'h0, 2'b10, 1'b0);
      applyStimulus(32'h0000_3FFC, 32'h0, 2'b10, 1'b0);
      applyStimulus(32'h0000_4000, 32'h0, 2'b10, 1'b0);
      applyStimulus(32'h0300_8000, 32'h0, 2'b00, 1'b0);
      applyStimulus(32'h0300_0020, 32'h0, 2'b11, 1'b0);
      applyStimulus(32'h0600_0002, 32'h1357_BEEF, 2'b01, 1'b1);
      applyStimulus(32'h0700_03FF, 32'h0000_003C, 2'b00, 1'b1);

      gfxOn = 1'b1;
      applyStimulus(32'h0200_0100, 32'h0, 2'b10, 1'b0);
      for (int n = 0; n < 120; n++) begin
         applyStimulus(randAddr(), $urandom(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      gfxOn = 1'b0;
      repeat (3) @(posedge clock);
      #1;

      bus_addr = 32'h0200_0010; bus_wdata = 32'h5555_AAAA; bus_size = 2'b10; bus_write = 1'b1;
      bus_req  = 1'b1;
      @(posedge clock); #1;
      checkOutput("rstTestIssueWe", 32'(mem_we_a), 32'hF);
      @(posedge clock); #1;
      checkOutput("rstTestWaitPause", 32'(bus_pause), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("midRstEnA", 32'(mem_en_a), 32'h3F);
      checkOutput("midRstEnB", 32'(mem_en_b), 32'h3F);
      checkOutput("midRstPause", 32'(bus_pause), 32'd0);
      checkOutput("midRstWe", 32'(mem_we_a), 32'd0);
      checkOutput("midRstWdata", mem_wdata_a, 32'd0);
      checkOutput("midRstAddr", mem_addr_a, 32'd0);
      checkOutput("midRstFault", 32'(bus_fault), 32'd0);
      checkOutput("midRstRdata", bus_rdata, 32'd0);
      bus_req = 1'b0;
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;
      weSeen = 0; enSeen = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (mem_we_a != 4'b0000) weSeen++;
         if (mem_en_a != '0) enSeen++;
         @(posedge clock); #1;
      end
      checkOutput("postRstWe", 32'(weSeen), 32'd0);
      checkOutput("postRstEn", 32'(enSeen), 32'd0);
      checkOutput("postRstPause", 32'(bus_pause), 32'd0);
      applyStimulus(32'h0200_0040, 32'h0, 2'b10, 1'b0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
